// File: rtl/pipelined_cla_alu.sv
// -----------------------------------------------------------------------------
// pipelined_cla_alu
//   Two-stage pipelined carry-lookahead add/subtract unit. It is the arithmetic
//   back end of the UART ALU command path. Supported ops are ADD, SUB, ADC and
//   SBB. A persistent carry flag chains multi-word arithmetic across
//   back-to-back transactions.
//
//   Stage 1 registers the conditioned operands. It also computes the low half
//   of a+b' for both possible carry-ins (carry-select).
//   Stage 2 resolves the carry-in, selects the low half, adds the high half
//   and produces the flags.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   in_valid    input transaction valid
//   in_ready    unit accepts input this cycle
//   in_a        operand A (two's complement, N bits)
//   in_b        operand B (two's complement, N bits)
//   in_op       00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid   result valid
//   out_ready   downstream accepts result
//   out_result  result (N bits, modulo 2^N)
//   out_flags   {C, V, N, Z, P}
//
// Handshake: valid/ready on both sides.
//   - A transfer happens on a rising edge where valid & ready are both 1.
//   - A producer holding valid must keep its data stable until the transfer.
//   - in_ready depends only on out_valid/out_ready, never on in_valid.
// -----------------------------------------------------------------------------
module pipelined_cla_alu #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [4:0]   out_flags
);

   localparam int HALF = N / 2;

   // HALF-bit lookahead adder returning {carry_out, sum}. Each carry is built
   // from the bitwise generate/propagate terms.
   function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] a,
                                              input logic [HALF-1:0] b,
                                              input logic            cin);
      logic [HALF-1:0] g;
      logic [HALF-1:0] p;
      logic [HALF:0]   c;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < HALF; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[HALF], p ^ c[HALF-1:0]};
   endfunction

   // Pipeline enable: the whole pipe moves together. Bubbles are not collapsed.
   logic en;
   logic accept;

   // Stage 1 registers
   logic            s1_valid_q;
   logic [HALF-1:0] s1_a_hi_q;
   logic [HALF-1:0] s1_b_hi_q;
   logic [1:0]      s1_op_q;
   logic [HALF-1:0] s1_sum0_q;
   logic [HALF-1:0] s1_sum1_q;
   logic            s1_c0_q;
   logic            s1_c1_q;

   // Stage 2 / output registers
   logic            out_valid_q;
   logic [N-1:0]    out_result_q;
   logic [4:0]      out_flags_q;
   logic            carry_q;

   // Stage 1 combinational
   logic [N-1:0]    b_cond;
   logic [HALF:0]   lo0;
   logic [HALF:0]   lo1;

   // Stage 2 combinational
   logic            cin;
   logic            lo_c;
   logic [HALF-1:0] lo_sum;
   logic [HALF:0]   hi;
   logic [N-1:0]    res_d;
   logic            ovf;
   logic [4:0]      flags_d;

   assign en       = ~out_valid_q | out_ready;
   assign in_ready = en;
   assign accept   = in_valid & en;

   always_comb begin
      // SUB/SBB add the inverted B operand. Their carry-in supplies the +1.
      b_cond = in_op[0] ? ~in_b : in_b;
      lo0    = cla_half(in_a[HALF-1:0], b_cond[HALF-1:0], 1'b0);
      lo1    = cla_half(in_a[HALF-1:0], b_cond[HALF-1:0], 1'b1);
   end

   always_comb begin
      // ADC/SBB take carry_q, which already holds the carry of the previous
      // transaction to leave stage 2. ADD uses 0 and SUB uses 1.
      cin     = s1_op_q[1] ? carry_q : s1_op_q[0];
      lo_c    = cin ? s1_c1_q   : s1_c0_q;
      lo_sum  = cin ? s1_sum1_q : s1_sum0_q;
      hi      = cla_half(s1_a_hi_q, s1_b_hi_q, lo_c);
      res_d   = {hi[HALF-1:0], lo_sum};
      ovf     = (s1_a_hi_q[HALF-1] == s1_b_hi_q[HALF-1]) &
                (res_d[N-1] != s1_a_hi_q[HALF-1]);
      flags_d = {hi[HALF], ovf, res_d[N-1], (res_d == '0), ~^res_d};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_hi_q    <= '0;
         s1_b_hi_q    <= '0;
         s1_op_q      <= '0;
         s1_sum0_q    <= '0;
         s1_sum1_q    <= '0;
         s1_c0_q      <= 1'b0;
         s1_c1_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
         carry_q      <= 1'b0;
      end else if (en) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_a_hi_q <= in_a[N-1:HALF];
            s1_b_hi_q <= b_cond[N-1:HALF];
            s1_op_q   <= in_op;
            s1_sum0_q <= lo0[HALF-1:0];
            s1_sum1_q <= lo1[HALF-1:0];
            s1_c0_q   <= lo0[HALF];
            s1_c1_q   <= lo1[HALF];
         end
         // A bubble in stage 1 releases the output and keeps its data.
         // Only real results touch carry_q.
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_result_q <= res_d;
            out_flags_q  <= flags_d;
            carry_q      <= flags_d[4];
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_flags  = out_flags_q;

endmodule
